seg_scan_receiver: RTL

- Receive-side counterpart of the multiplexed 4-digit 7-segment scan driver.
- Samples the scanned `seg`/`an` bus and decodes each segment pattern back to a BCD digit.
- Assembles the four digits into an HH:MM frame and flags protocol or content errors.
- Used for on-board self-test and as the bench monitor for the clock display path; sits beside the display driver, fed from its outputs.

---
 rtl/seg_scan_receiver.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_receiver.sv
// rtl/seg_scan_receiver.sv - decodes a scanned 4-digit 7-segment bus back into an HH:MM frame
module seg_scan_receiver #(
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 1048576,
  parameter int CNT_W   = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg,
  input  logic [3:0] an,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       frame_valid,
  output logic       time_ok,
  output logic       seg_err,
  output logic       an_err,
  output logic       stall
);

  typedef enum logic {HUNT, CAPTURE} state_t;

  state_t           state;
  logic [6:0]       seg_s1, seg_s2;
  logic [3:0]       an_s1, an_s2, an_prev;
  logic [CNT_W-1:0] settle_cnt, tmo_cnt;
  logic [3:0]       mask;
  logic [3:0][3:0]  stage;

  logic       changed, settle_hit, tmo_hit, an_idle, an_legal, dec_ok;
  logic [1:0] pos;
  logic [3:0] dec_val;

  // Synchronisers idle at blank/all-anodes-off so reset itself never looks like a phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_s1  <= 7'h7F;
      seg_s2  <= 7'h7F;
      an_s1   <= 4'hF;
      an_s2   <= 4'hF;
      an_prev <= 4'hF;
    end else begin
      seg_s1  <= seg;
      seg_s2  <= seg_s1;
      an_s1   <= an;
      an_s2   <= an_s1;
      an_prev <= an_s2;
    end
  end

  assign changed    = (an_s2 != an_prev);
  assign settle_hit = !changed && (settle_cnt == CNT_W'(SETTLE - 1));
  assign tmo_hit    = !changed && (tmo_cnt == CNT_W'(TIMEOUT - 1));
  assign an_idle    = (an_s2 == 4'b1111);

  always_comb begin
    an_legal = 1'b1;
    pos      = 2'd0;
    case (an_s2)
      4'b1110: pos = 2'd0;
      4'b1101: pos = 2'd1;
      4'b1011: pos = 2'd2;
      4'b0111: pos = 2'd3;
      default: an_legal = 1'b0;
    endcase
  end

  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'd0;
    case (seg_s2)
      7'b1000000: dec_val = 4'd0;
      7'b1111001: dec_val = 4'd1;
      7'b0100100: dec_val = 4'd2;
      7'b0110000: dec_val = 4'd3;
      7'b0011001: dec_val = 4'd4;
      7'b0010010: dec_val = 4'd5;
      7'b0000010: dec_val = 4'd6;
      7'b1111000: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0010000: dec_val = 4'd9;
      7'b1111111: dec_val = 4'd0;
      default:    dec_ok  = 1'b0;
    endcase
  end

  // Both counters saturate, so a settle hit fires once per anode phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      stall      <= 1'b0;
    end else if (changed) begin
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      stall      <= 1'b0;
    end else begin
      if (settle_cnt != CNT_W'(SETTLE))
        settle_cnt <= settle_cnt + 1'b1;
      if (tmo_cnt != CNT_W'(TIMEOUT))
        tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit)
        stall <= 1'b1;
    end
  end

  function automatic logic legal_time(input logic [3:0][3:0] d);
    logic hour_ok;
    hour_ok = (d[3] <= 4'd2) && ((d[3] == 4'd2) ? (d[2] <= 4'd3) : (d[2] <= 4'd9));
    return hour_ok && (d[1] <= 4'd5) && (d[0] <= 4'd9);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= HUNT;
      mask        <= 4'b0000;
      stage       <= '0;
      digit0      <= 4'd0;
      digit1      <= 4'd0;
      digit2      <= 4'd0;
      digit3      <= 4'd0;
      frame_valid <= 1'b0;
      time_ok     <= 1'b0;
      seg_err     <= 1'b0;
      an_err      <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (tmo_hit) begin
        mask  <= 4'b0000;
        state <= HUNT;
      end else if (state == CAPTURE && mask == 4'b1111) begin
        digit0      <= stage[0];
        digit1      <= stage[1];
        digit2      <= stage[2];
        digit3      <= stage[3];
        time_ok     <= legal_time(stage);
        frame_valid <= 1'b1;
        mask        <= 4'b0000;
      end else if (settle_hit && !an_idle) begin
        if (!an_legal) begin
          an_err <= 1'b1;
          mask   <= 4'b0000;
          state  <= HUNT;
        end else if (!dec_ok) begin
          seg_err <= 1'b1;
          mask    <= 4'b0000;
          state   <= HUNT;
        end else begin
          stage[pos] <= dec_val;
          mask[pos]  <= 1'b1;
          state      <= CAPTURE;
        end
      end
    end
  end

endmodule
